// File: rtl/ryuki_datatypes.sv
// Shared trace record types for the Ryuki tracers: the per-fetch trace record,
// the in-flight fetch bookkeeping entry, and a helper that turns one into the other.
package ryuki_datatypes;

  localparam int TRACE_TS_W    = 32;
  localparam int TRACE_ADDR_W  = 32;
  localparam int TRACE_INSTR_W = 32;

  typedef struct packed {
    logic [TRACE_TS_W-1:0] time_start;
    logic [TRACE_TS_W-1:0] time_end;
  } trace_span_t;

  typedef struct packed {
    logic [TRACE_ADDR_W-1:0]  pc;
    logic [TRACE_INSTR_W-1:0] instruction;
    trace_span_t              if_data;
    trace_span_t              mem_access_req;
    trace_span_t              mem_access_res;
  } trace_output;

  typedef struct packed {
    logic [TRACE_ADDR_W-1:0] addr;
    logic [TRACE_TS_W-1:0]   if_start;
    logic [TRACE_TS_W-1:0]   req_start;
    logic [TRACE_TS_W-1:0]   req_end;
    logic [TRACE_TS_W-1:0]   res_start;
  } if_inflight_t;

  // The response cycle closes both the fetch span and the memory response span.
  function automatic trace_output build_record(input if_inflight_t e,
                                               input logic [TRACE_INSTR_W-1:0] instr,
                                               input logic [TRACE_TS_W-1:0] now);
    trace_output r;
    r.pc                        = e.addr;
    r.instruction               = instr;
    r.if_data.time_start        = e.if_start;
    r.if_data.time_end          = now;
    r.mem_access_req.time_start = e.req_start;
    r.mem_access_req.time_end   = e.req_end;
    r.mem_access_res.time_start = e.res_start;
    r.mem_access_res.time_end   = now;
    return r;
  endfunction

endpackage

// File: rtl/trace_sync_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on dout whenever the FIFO is non-empty.
// The caller never pushes when full without a same-cycle pop, and never pops when empty.
module trace_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  T            mem_reg [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg[AW-1:0] == AW'(gi))) mem_reg[gi] <= din;
    end
  end

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign dout  = mem_reg[rd_ptr_reg[AW-1:0]];
  assign count = wr_ptr_reg - rd_ptr_reg;
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/if_trace_tracker.sv
// Instruction-fetch tracer: snoops the IF memory bus, times each fetch from first request to
// response, and queues one trace record per completed fetch for a valid/ready consumer.
module if_trace_tracker
  import ryuki_datatypes::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int OUT_DEPTH       = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               instr_req,
  input  logic [ADDR_WIDTH-1:0]              instr_addr,
  input  logic                               instr_grant,
  input  logic                               instr_rvalid,
  input  logic [DATA_WIDTH-1:0]              instr_rdata,
  input  logic [31:0]                        counter,
  output logic                               trace_valid_o,
  input  logic                               trace_ready_i,
  output trace_output                        trace_data_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic [CNT_WIDTH-1:0]               drop_count_o,
  output logic                               overflow_o,
  output logic                               protocol_err_o
);

  logic                    req_pending_reg;
  logic [TRACE_TS_W-1:0]   req_start_reg;
  logic [CNT_WIDTH-1:0]    drop_count_reg;
  logic                    overflow_reg;
  logic                    protocol_err_reg;

  logic                    accept, if_pop, if_push, if_full, if_empty, if_drop;
  logic                    out_push, out_pop, out_full, out_empty, out_drop;
  logic [$clog2(OUT_DEPTH):0] out_count;
  logic [TRACE_TS_W-1:0]   req_start_eff;
  if_inflight_t            if_din, if_head;
  trace_output             rec, out_head;
  logic [CNT_WIDTH:0]      drop_sum;
  logic [CNT_WIDTH-1:0]    drop_count_next;

  // A grant in the very first request cycle uses that cycle's timestamp.
  assign req_start_eff = req_pending_reg ? req_start_reg : counter;
  assign accept        = instr_req && instr_grant;

  // Pop precedes push, so a full in-flight buffer still accepts alongside a response.
  assign if_pop  = instr_rvalid && !if_empty;
  assign if_push = accept && (!if_full || if_pop);
  assign if_drop = accept && if_full && !if_pop;

  assign if_din.addr      = TRACE_ADDR_W'(instr_addr);
  assign if_din.if_start  = req_start_eff;
  assign if_din.req_start = req_start_eff;
  assign if_din.req_end   = counter;
  assign if_din.res_start = counter;

  trace_sync_fifo #(.T(if_inflight_t), .DEPTH(MAX_OUTSTANDING)) u_inflight (
    .clk   (clk),
    .rst   (rst),
    .push  (if_push),
    .din   (if_din),
    .pop   (if_pop),
    .dout  (if_head),
    .full  (if_full),
    .empty (if_empty),
    .count (outstanding_o)
  );

  assign rec      = build_record(if_head, TRACE_INSTR_W'(instr_rdata), counter);
  assign out_pop  = trace_valid_o && trace_ready_i;
  assign out_push = if_pop && (!out_full || out_pop);
  assign out_drop = if_pop && out_full && !out_pop;

  trace_sync_fifo #(.T(trace_output), .DEPTH(OUT_DEPTH)) u_out (
    .clk   (clk),
    .rst   (rst),
    .push  (out_push),
    .din   (rec),
    .pop   (out_pop),
    .dout  (out_head),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  assign trace_valid_o = (out_count != '0);
  assign trace_data_o  = out_empty ? '0 : out_head;

  // Both drop causes can land in one cycle; the count saturates instead of wrapping.
  assign drop_sum        = {1'b0, drop_count_reg} + (CNT_WIDTH+1)'(if_drop)
                                                  + (CNT_WIDTH+1)'(out_drop);
  assign drop_count_next = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      req_pending_reg  <= 1'b0;
      req_start_reg    <= '0;
      drop_count_reg   <= '0;
      overflow_reg     <= 1'b0;
      protocol_err_reg <= 1'b0;
    end else begin
      if (instr_grant) begin
        req_pending_reg <= 1'b0;
      end else if (instr_req && !req_pending_reg) begin
        req_pending_reg <= 1'b1;
        req_start_reg   <= counter;
      end
      drop_count_reg <= drop_count_next;
      if (if_drop || out_drop)       overflow_reg     <= 1'b1;
      if (instr_rvalid && if_empty)  protocol_err_reg <= 1'b1;
    end
  end

  assign drop_count_o   = drop_count_reg;
  assign overflow_o     = overflow_reg;
  assign protocol_err_o = protocol_err_reg;

endmodule

// File: tb/tb_if_trace_tracker.sv
// Directed bench for if_trace_tracker: a small bus model predicts records into a
// scoreboard queue, and a consumer-side monitor pops and compares each delivered record.
module tb_if_trace_tracker;
  import ryuki_datatypes::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = '0;
  logic        instr_grant = 1'b0;
  logic        instr_rvalid = 1'b0;
  logic [31:0] instr_rdata = '0;
  logic [31:0] counter = '0;
  logic        trace_ready_i = 1'b1;
  logic        trace_valid_o;
  trace_output trace_data_o;
  logic [2:0]  outstanding_o;
  logic [15:0] drop_count_o;
  logic        overflow_o;
  logic        protocol_err_o;

  if_trace_tracker dut (
    .clk            (clk),
    .rst            (rst),
    .instr_req      (instr_req),
    .instr_addr     (instr_addr),
    .instr_grant    (instr_grant),
    .instr_rvalid   (instr_rvalid),
    .instr_rdata    (instr_rdata),
    .counter        (counter),
    .trace_valid_o  (trace_valid_o),
    .trace_ready_i  (trace_ready_i),
    .trace_data_o   (trace_data_o),
    .outstanding_o  (outstanding_o),
    .drop_count_o   (drop_count_o),
    .overflow_o     (overflow_o),
    .protocol_err_o (protocol_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rs;
    logic [31:0] re;
  } mentry_t;

  int          tests = 0;
  int          fails = 0;
  trace_output exp_q[$];
  mentry_t     mq[$];
  int          m_drops = 0;
  bit          m_ovf = 1'b0;
  bit          m_perr = 1'b0;
  bit          m_pend = 1'b0;
  logic [31:0] m_rs = '0;

  function automatic trace_output mk(input logic [31:0] pc, input logic [31:0] ins,
                                     input logic [31:0] ifs, input logic [31:0] ife,
                                     input logic [31:0] rqs, input logic [31:0] rqe,
                                     input logic [31:0] rss, input logic [31:0] rse);
    trace_output r;
    r.pc = pc;
    r.instruction = ins;
    r.if_data.time_start = ifs;
    r.if_data.time_end = ife;
    r.mem_access_req.time_start = rqs;
    r.mem_access_req.time_end = rqe;
    r.mem_access_res.time_start = rss;
    r.mem_access_res.time_end = rse;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input trace_output obs, input trace_output exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_outstanding"}, 64'(outstanding_o), 64'(mq.size()));
    chk({tag, "_drops"}, 64'(drop_count_o), 64'(m_drops));
    chk({tag, "_overflow"}, 64'(overflow_o), 64'(m_ovf));
    chk({tag, "_proto_err"}, 64'(protocol_err_o), 64'(m_perr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    counter = counter + 1;
  endtask

  // Drive one bus cycle and predict its effect before the clock edge.
  task automatic cyc(input logic req, input logic [31:0] addr, input logic gnt,
                     input logic rv, input logic [31:0] data);
    mentry_t     e;
    logic [31:0] rs_eff;
    instr_req = req;
    instr_addr = addr;
    instr_grant = gnt;
    instr_rvalid = rv;
    instr_rdata = data;
    rs_eff = m_pend ? m_rs : counter;
    if (rv) begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        if (exp_q.size() < 4 || trace_ready_i)
          exp_q.push_back(mk(e.addr, data, e.rs, counter, e.rs, e.re, e.re, counter));
        else begin
          m_drops++;
          m_ovf = 1'b1;
        end
      end else begin
        m_perr = 1'b1;
      end
    end
    if (req && gnt) begin
      if (mq.size() < 4) mq.push_back('{addr, rs_eff, counter});
      else begin
        m_drops++;
        m_ovf = 1'b1;
      end
    end
    if (gnt) m_pend = 1'b0;
    else if (req && !m_pend) begin
      m_pend = 1'b1;
      m_rs = counter;
    end
    tick();
    instr_req = 1'b0;
    instr_grant = 1'b0;
    instr_rvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    instr_req = 1'b0;
    instr_grant = 1'b0;
    instr_rvalid = 1'b0;
    tick();
    mq.delete();
    exp_q.delete();
    m_drops = 0;
    m_ovf = 1'b0;
    m_perr = 1'b0;
    m_pend = 1'b0;
    chk({tag, "_valid"}, 64'(trace_valid_o), 64'd0);
    chk({tag, "_data"}, 64'(trace_data_o != '0), 64'd0);
    chk({tag, "_outstanding"}, 64'(outstanding_o), 64'd0);
    chk({tag, "_drops"}, 64'(drop_count_o), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow_o), 64'd0);
    chk({tag, "_proto_err"}, 64'(protocol_err_o), 64'd0);
    rst = 1'b0;
  endtask

  // Consumer side: every accepted record must match the oldest predicted one.
  always @(negedge clk) begin : monitor
    trace_output e;
    if (!rst && trace_valid_o === 1'b1 && trace_ready_i) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_record observed=%h expected=none", trace_data_o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk_rec("record", trace_data_o, e);
        $display("[TB] t=%0t record pc=%h instr=%h if=%0d..%0d", $time, trace_data_o.pc,
                 trace_data_o.instruction, trace_data_o.if_data.time_start,
                 trace_data_o.if_data.time_end);
      end
    end
  end

  initial begin : stim
    int          peak;
    trace_output held;

    do_reset("reset");

    // Single fetch with a two-cycle grant wait.
    trace_ready_i = 1'b1;
    counter = 32'd10;
    cyc(1'b1, 32'h0000_1000, 1'b0, 1'b0, '0);
    cyc(1'b1, 32'h0000_1000, 1'b0, 1'b0, '0);
    cyc(1'b1, 32'h0000_1000, 1'b1, 1'b0, '0);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    chk("t1_valid_before_rvalid", 64'(trace_valid_o), 64'd0);
    chk("t1_outstanding_1", 64'(outstanding_o), 64'd1);
    cyc(1'b0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("t1_counter_16", 64'(counter), 64'd16);
    chk("t1_valid_at_16", 64'(trace_valid_o), 64'd1);
    chk_rec("t1_record", trace_data_o,
            mk(32'h0000_1000, 32'hDEAD_BEEF, 32'd10, 32'd15, 32'd10, 32'd12, 32'd12, 32'd15));
    idle(2);
    chk_state("t1");

    // Pipelined fetches, responses two cycles behind grants.
    counter = 32'd5;
    peak = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(i < 4, 32'h2000 + 32'(4 * i), i < 4, i >= 2, 32'hA000_0000 + 32'(i - 2));
      if (int'(outstanding_o) > peak) peak = int'(outstanding_o);
    end
    idle(2);
    chk("t2_peak_outstanding", 64'(peak), 64'd2);
    chk("t2_drops", 64'(drop_count_o), 64'd0);
    chk_state("t2");

    // In-flight overflow, then accept-at-full, then drain and a stray response.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h3000 + 32'(4 * i), 1'b1, 1'b0, '0);
    chk("t3_outstanding_4", 64'(outstanding_o), 64'd4);
    chk("t3_drop_1", 64'(drop_count_o), 64'd1);
    chk("t3_overflow", 64'(overflow_o), 64'd1);
    cyc(1'b1, 32'h3100, 1'b1, 1'b1, 32'hB000_0000);
    chk("t5_outstanding_still_4", 64'(outstanding_o), 64'd4);
    chk("t5_drop_still_1", 64'(drop_count_o), 64'd1);
    for (int i = 1; i <= 4; i++) cyc(1'b0, '0, 1'b0, 1'b1, 32'hB000_0000 + 32'(i));
    chk("t5_outstanding_0", 64'(outstanding_o), 64'd0);
    chk("t5_proto_err_clear", 64'(protocol_err_o), 64'd0);
    cyc(1'b0, '0, 1'b0, 1'b1, 32'hBAD0_0000);
    chk("t5_proto_err_set", 64'(protocol_err_o), 64'd1);
    idle(3);
    chk_state("t5");

    // Output backpressure: six completions into a four-entry buffer.
    do_reset("reset2");
    trace_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 32'h4000 + 32'(4 * i), 1'b1, 1'b0, '0);
      cyc(1'b0, '0, 1'b0, 1'b1, 32'hC000_0000 + 32'(i));
    end
    chk("t4_drop_2", 64'(drop_count_o), 64'd2);
    chk("t4_valid", 64'(trace_valid_o), 64'd1);
    chk("t4_head_pc", 64'(trace_data_o.pc), 64'h4000);
    held = trace_data_o;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk_rec("t4_stable", trace_data_o, held);
    end
    trace_ready_i = 1'b1;
    idle(6);
    chk("t4_drained", 64'(exp_q.size()), 64'd0);
    chk("t4_valid_low", 64'(trace_valid_o), 64'd0);
    chk_state("t4");

    // Reset with work in flight and queued, then a clean fetch.
    trace_ready_i = 1'b0;
    cyc(1'b1, 32'h5000, 1'b1, 1'b0, '0);
    cyc(1'b1, 32'h5004, 1'b1, 1'b0, '0);
    cyc(1'b1, 32'h5008, 1'b1, 1'b1, 32'hD000_0000);
    cyc(1'b1, 32'h500C, 1'b1, 1'b1, 32'hD000_0001);
    cyc(1'b1, 32'h5010, 1'b1, 1'b0, '0);
    chk("t6_outstanding_3", 64'(outstanding_o), 64'd3);
    chk("t6_queued_valid", 64'(trace_valid_o), 64'd1);
    do_reset("t6_reset");
    trace_ready_i = 1'b1;
    counter = 32'd100;
    cyc(1'b1, 32'h6000, 1'b1, 1'b0, '0);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    cyc(1'b0, '0, 1'b0, 1'b1, 32'hE000_0000);
    chk_rec("t6_record", trace_data_o,
            mk(32'h6000, 32'hE000_0000, 32'd100, 32'd102, 32'd100, 32'd100, 32'd100, 32'd102));
    idle(2);
    cyc(1'b0, '0, 1'b0, 1'b1, 32'hBAD1_0000);
    chk("t6_late_rvalid_proto_err", 64'(protocol_err_o), 64'd1);
    idle(2);
    chk_state("t6");
    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
